// File: rtl/pixel_window_buffer.sv
// pixel_window_buffer
//   Turns a raster pixel stream into a sliding KxK window stream. K-1 circular
//   line delays of IMG_W-K pixels feed a KxK register window. Each accepted
//   pixel (x,y) with x>=K-1 and y>=K-1 produces one window anchored at
//   (x-K+1, y-K+1), one cycle later, behind a single output register.
//
//   Optional feature macro: WINBUF_EOL_FLAGS_EN adds the out_eol/out_eof
//   outputs. out_eol marks the last window of a line. out_eof marks the last
//   window of a frame.
//
//   Ports
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     in_valid    upstream pixel valid
//     in_ready    pixel accepted this cycle when in_valid is also high
//     in_data     pixel, raster order, frames back to back
//     out_valid   window valid
//     out_ready   downstream takes the window
//     out_win     KxK window; slice (i*K+j)*DW is pixel (r+i, c+j), i=0 oldest
//     out_col     window anchor column c
//     out_row     window anchor row r
//     frame_done  one-cycle pulse after the last pixel of a frame is accepted
//     out_eol     (WINBUF_EOL_FLAGS_EN) window anchor c = IMG_W-K
//     out_eof     (WINBUF_EOL_FLAGS_EN) window anchor c = IMG_W-K and r = IMG_H-K
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   FILL   | rows 0..K-2 are arriving; the line delays are priming
//   RUN    | rows K-1..IMG_H-1; windows are emitted from column K-1 onward
//   DONE   | one cycle after the last pixel; pulses frame_done, input held off
module pixel_window_buffer #(
  parameter int DW    = 24,
  parameter int IMG_W = 960,
  parameter int IMG_H = 540,
  parameter int K     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K*K*DW-1:0] out_win,
  output logic [11:0]       out_col,
  output logic [11:0]       out_row,
  output logic              frame_done
`ifdef WINBUF_EOL_FLAGS_EN
  ,
  output logic              out_eol,
  output logic              out_eof
`endif
);

  localparam int L  = IMG_W - K;
  localparam int PW = (L > 1) ? $clog2(L) : 1;

  localparam logic [11:0]   X_LAST      = 12'(IMG_W - 1);
  localparam logic [11:0]   Y_LAST      = 12'(IMG_H - 1);
  localparam logic [11:0]   K_M1        = 12'(K - 1);
  localparam logic [11:0]   Y_FILL_LAST = 12'(K - 2);
  localparam logic [PW-1:0] PTR_LAST    = PW'(L - 1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [11:0]     r_x;
  logic [11:0]     r_y;
  logic [PW-1:0]   r_ptr;
  logic [DW-1:0]   r_win      [K][K];
  logic [DW-1:0]   w_win_next [K][K];
  logic [DW-1:0]   r_line     [K-1][L];
  logic [DW-1:0]   w_line_out [K-1];
  logic [K*K*DW-1:0] r_out_win;
  logic            r_out_valid;
  logic [11:0]     r_out_col;
  logic [11:0]     r_out_row;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_x_last;
  logic            w_load;

  // The DONE gap keeps the frame boundary visible to upstream and lets the
  // counters settle before the next frame's first pixel.
  assign w_in_ready = (~r_out_valid | out_ready) & (r_state != S_DONE);
  assign w_accept   = in_valid & w_in_ready;
  assign w_x_last   = (r_x == X_LAST);
  assign w_load     = w_accept & (r_x >= K_M1) & (r_y >= K_M1);

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_win    = r_out_win;
  assign out_col    = r_out_col;
  assign out_row    = r_out_row;
  assign frame_done = (r_state == S_DONE);

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:  if (w_accept && w_x_last && (r_y == Y_FILL_LAST)) w_state_next = S_RUN;
      S_RUN:   if (w_accept && w_x_last && (r_y == Y_LAST))      w_state_next = S_DONE;
      S_DONE:  w_state_next = S_FILL;
      default: w_state_next = S_FILL;
    endcase
  end

  // Raster position counters and the shared line-delay slot pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_ptr <= PTR_LAST;
    end else if (r_state == S_DONE) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? 12'd0 : r_y + 12'd1;
      end else begin
        r_x <= r_x + 12'd1;
      end
      r_ptr <= (r_ptr == '0) ? PTR_LAST : r_ptr - PW'(1);
    end
  end

  // Next window: every row shifts left by one column. The newest row takes the
  // incoming pixel. Each older row takes its line-delay output, which is the
  // same column exactly one line earlier.
  always_comb begin
    for (int i = 0; i < K - 1; i++) w_line_out[i] = r_line[i][r_ptr];
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) w_win_next[i][j] = r_win[i][j+1];
      w_win_next[i][K-1] = in_data;
    end
    for (int i = 0; i < K - 1; i++) w_win_next[i][K-1] = w_line_out[i];
  end

  // Pixel storage is not reset. The first window after reset needs K-1 full
  // lines of fresh input, which flushes anything stale first.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          r_win[i][j] <= w_win_next[i][j];
      // Each slot is read before it is overwritten. Together with the K-column
      // window row, this gives a delay of exactly IMG_W accepts per line.
      for (int i = 0; i < K - 1; i++)
        r_line[i][r_ptr] <= r_win[i+1][0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_load)
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          r_out_win[(i*K+j)*DW +: DW] <= w_win_next[i][j];
  end

  // Output register. A load can only happen when the slot is free or is being
  // handed off in the same cycle, because in_ready already gates accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_row   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_col   <= r_x - K_M1;
      r_out_row   <= r_y - K_M1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef WINBUF_EOL_FLAGS_EN
  logic r_out_eol;
  logic r_out_eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_eol <= 1'b0;
      r_out_eof <= 1'b0;
    end else if (w_load) begin
      r_out_eol <= w_x_last;
      r_out_eof <= w_x_last & (r_y == Y_LAST);
    end
  end

  assign out_eol = r_out_eol;
  assign out_eof = r_out_eof;
`endif

endmodule

// File: tb/tb_pixel_window_buffer.sv
module tb_pixel_window_buffer;
  localparam int DW = 24;
  localparam int W  = 8;
  localparam int H  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic              in_valid, in_ready, out_valid, out_ready, frame_done;
  logic [DW-1:0]     in_data;
  logic [16*DW-1:0]  out_win;
  logic [11:0]       out_col, out_row;

  logic              in_valid2, in_ready2, out_valid2, out_ready2, frame_done2;
  logic [DW-1:0]     in_data2;
  logic [4*DW-1:0]   out_win2;
  logic [11:0]       out_col2, out_row2;

`ifdef WINBUF_EOL_FLAGS_EN
  logic out_eol, out_eof, out_eol2, out_eof2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_window_buffer #(.DW(DW), .IMG_W(W), .IMG_H(H), .K(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
    .out_col(out_col), .out_row(out_row), .frame_done(frame_done)
`ifdef WINBUF_EOL_FLAGS_EN
    , .out_eol(out_eol), .out_eof(out_eof)
`endif
  );

  pixel_window_buffer #(.DW(DW), .IMG_W(W), .IMG_H(H), .K(2)) dut_k2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_win(out_win2),
    .out_col(out_col2), .out_row(out_row2), .frame_done(frame_done2)
`ifdef WINBUF_EOL_FLAGS_EN
    , .out_eol(out_eol2), .out_eof(out_eof2)
`endif
  );

  // pixel p of a frame in raster order, value {row,col}
  function automatic logic [DW-1:0] pix(int p);
    return DW'(((p / W) << 4) | (p % W));
  endfunction

  function automatic logic [16*DW-1:0] exp_win(int kk, int c, int r);
    logic [16*DW-1:0] w = '0;
    for (int i = 0; i < kk; i++)
      for (int j = 0; j < kk; j++)
        w[(i*kk+j)*DW +: DW] = DW'(((r + i) << 4) | (c + j));
    return w;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b exp 0", frame_done); end
    checks++; if (out_col !== 12'd0 || out_row !== 12'd0) begin errors++; $display("FAIL reset_anchor got c=%0d r=%0d exp 0,0", out_col, out_row); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_rel got %0b exp 0", out_valid); end
    checks++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_k2 got rdy=%0b vld=%0b exp 1,0", in_ready2, out_valid2); end
  endtask

  task automatic test_stream();
    int p, nwin, nfd, acc27, acc48, first_win;
    logic [16*DW-1:0] ew;
    do_reset();
    p = 0; nwin = 0; nfd = 0; acc27 = -1; acc48 = -1; first_win = -1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      in_valid = (p < 48); in_data = pix(p % 48); out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        ew = exp_win(4, nwin % 5, nwin / 5);
        checks++; if (out_win !== ew) begin errors++; $display("FAIL stream_win%0d got %h exp %h", nwin, out_win, ew); end
        checks++; if (out_col !== 12'(nwin % 5) || out_row !== 12'(nwin / 5)) begin errors++; $display("FAIL stream_anchor%0d got c=%0d r=%0d exp c=%0d r=%0d", nwin, out_col, out_row, nwin % 5, nwin / 5); end
`ifdef WINBUF_EOL_FLAGS_EN
        checks++; if (out_eol !== ((nwin % 5) == 4)) begin errors++; $display("FAIL stream_eol%0d got %0b", nwin, out_eol); end
        checks++; if (out_eof !== (nwin == 14)) begin errors++; $display("FAIL stream_eof%0d got %0b", nwin, out_eof); end
`endif
        if (nwin == 0) begin
          first_win = cyc;
          checks++; if (out_win[0 +: DW] !== 24'h000000 || out_win[15*DW +: DW] !== 24'h000033) begin errors++; $display("FAIL stream_first_slices got s0=%h s15=%h exp 00,33", out_win[0 +: DW], out_win[15*DW +: DW]); end
        end
        nwin++;
      end
      if (frame_done) begin
        nfd++;
        checks++; if (cyc != acc48 + 1) begin errors++; $display("FAIL stream_done_time got cyc %0d exp %0d", cyc, acc48 + 1); end
      end
      if (in_valid && in_ready) begin
        if (p == 27) acc27 = cyc;
        if (p == 47) acc48 = cyc;
        p++;
      end
    end
    checks++; if (first_win != acc27 + 1) begin errors++; $display("FAIL stream_latency got cyc %0d exp %0d", first_win, acc27 + 1); end
    checks++; if (nwin != 15) begin errors++; $display("FAIL stream_count got %0d exp 15", nwin); end
    checks++; if (nfd != 1) begin errors++; $display("FAIL stream_done_count got %0d exp 1", nfd); end
  endtask

  task automatic test_backpressure();
    int p, nwin, stall;
    bit stalled;
    logic [16*DW-1:0] ew, snap_win;
    logic [11:0] snap_col, snap_row;
    do_reset();
    p = 0; nwin = 0; stall = 0; stalled = 1'b0;
    snap_win = '0; snap_col = '0; snap_row = '0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(negedge clk);
      if (!stalled && out_valid && nwin == 5) begin
        stall = 5; stalled = 1'b1;
        snap_win = out_win; snap_col = out_col; snap_row = out_row;
      end
      in_valid = (p < 48); in_data = pix(p % 48); out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_win !== snap_win || out_col !== snap_col || out_row !== snap_row) begin errors++; $display("FAIL bp_hold got vld=%0b c=%0d r=%0d exp 1 c=%0d r=%0d", out_valid, out_col, out_row, snap_col, snap_row); end
        stall--;
      end
      if (out_valid && out_ready) begin
        ew = exp_win(4, nwin % 5, nwin / 5);
        checks++; if (out_win !== ew || out_col !== 12'(nwin % 5) || out_row !== 12'(nwin / 5)) begin errors++; $display("FAIL bp_win%0d got c=%0d r=%0d %h exp c=%0d r=%0d %h", nwin, out_col, out_row, out_win, nwin % 5, nwin / 5, ew); end
        nwin++;
      end
      if (in_valid && in_ready) p++;
    end
    checks++; if (!stalled) begin errors++; $display("FAIL bp_stall_reached got 0 exp 1"); end
    checks++; if (nwin != 15) begin errors++; $display("FAIL bp_count got %0d exp 15", nwin); end
  endtask

  task automatic test_back_to_back();
    int p, nwin, nfd, nlow;
    logic [16*DW-1:0] ew;
    do_reset();
    p = 0; nwin = 0; nfd = 0; nlow = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      in_valid = (p < 96); in_data = pix(p % 48); out_ready = 1'b1;
      #1;
      if (in_valid && !in_ready) nlow++;
      if (frame_done) begin
        nfd++;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_ready got %0b exp 0", in_ready); end
      end
      if (out_valid && out_ready) begin
        ew = exp_win(4, (nwin % 15) % 5, (nwin % 15) / 5);
        checks++; if (out_win !== ew || out_col !== 12'((nwin % 15) % 5) || out_row !== 12'((nwin % 15) / 5)) begin errors++; $display("FAIL b2b_win%0d got c=%0d r=%0d %h exp %h", nwin, out_col, out_row, out_win, ew); end
        nwin++;
      end
      if (in_valid && in_ready) p++;
    end
    checks++; if (nwin != 30) begin errors++; $display("FAIL b2b_count got %0d exp 30", nwin); end
    checks++; if (nfd != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", nfd); end
    checks++; if (nlow != 1) begin errors++; $display("FAIL b2b_ready_low got %0d exp 1", nlow); end
  endtask

  task automatic test_reset_midframe();
    int p, nwin;
    logic [16*DW-1:0] ew;
    do_reset();
    p = 0;
    for (int cyc = 0; cyc < 40 && p < 20; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = pix(p) ^ 24'hA5C300; out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) p++;
    end
    checks++; if (p != 20) begin errors++; $display("FAIL mid_pre_accepts got %0d exp 20", p); end
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_col !== 12'd0 || out_row !== 12'd0) begin errors++; $display("FAIL mid_reset_outs got vld=%0b fd=%0b c=%0d r=%0d exp 0", out_valid, frame_done, out_col, out_row); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %0b exp 1", in_ready); end
    p = 0; nwin = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      in_valid = (p < 48); in_data = pix(p % 48); out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        ew = exp_win(4, nwin % 5, nwin / 5);
        checks++; if (out_win !== ew || out_col !== 12'(nwin % 5) || out_row !== 12'(nwin / 5)) begin errors++; $display("FAIL mid_win%0d got c=%0d r=%0d %h exp %h", nwin, out_col, out_row, out_win, ew); end
        nwin++;
      end
      if (in_valid && in_ready) p++;
    end
    checks++; if (nwin != 15) begin errors++; $display("FAIL mid_count got %0d exp 15", nwin); end
  endtask

  task automatic test_k2();
    int p, nwin, nfd;
    logic [16*DW-1:0] ew;
    do_reset();
    p = 0; nwin = 0; nfd = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      in_valid2 = (p < 48); in_data2 = pix(p % 48); out_ready2 = 1'b1;
      #1;
      if (frame_done2) nfd++;
      if (out_valid2 && out_ready2) begin
        ew = exp_win(2, nwin % 7, nwin / 7);
        checks++; if (out_win2 !== ew[4*DW-1:0] || out_col2 !== 12'(nwin % 7) || out_row2 !== 12'(nwin / 7)) begin errors++; $display("FAIL k2_win%0d got c=%0d r=%0d %h exp %h", nwin, out_col2, out_row2, out_win2, ew[4*DW-1:0]); end
        if (nwin == 0) begin
          checks++;
          if (out_win2[0 +: DW] !== 24'h00 || out_win2[DW +: DW] !== 24'h01 || out_win2[2*DW +: DW] !== 24'h10 || out_win2[3*DW +: DW] !== 24'h11) begin
            errors++; $display("FAIL k2_first got %h exp 000011_000010_000001_000000", out_win2);
          end
        end
        nwin++;
      end
      if (in_valid2 && in_ready2) p++;
    end
    checks++; if (nwin != 35) begin errors++; $display("FAIL k2_count got %0d exp 35", nwin); end
    checks++; if (nfd != 1) begin errors++; $display("FAIL k2_done_count got %0d exp 1", nfd); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_k2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_window_buffer.md
PIXEL_WINDOW_BUFFER -- requirements
Module: pixel_window_buffer

Interface
REQ-001 SHALL have parameter DW, default 24, bits per pixel (packed RGB).
REQ-002 SHALL have parameter IMG_W, default 960, source pixels per line; legal range K+1..4095.
REQ-003 SHALL have parameter IMG_H, default 540, source lines per frame; legal range K..4095.
REQ-004 SHALL have parameter K, default 4, window edge length; legal range 2..4.
REQ-005 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1, upstream pixel valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts a pixel this cycle.
REQ-009 SHALL have port in_data, input, DW, pixel, raster order, frames back to back.
REQ-010 SHALL have port out_valid, output, 1, window valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the window.
REQ-012 SHALL have port out_win, output, K*K*DW, window; slice (i*K+j)*DW +: DW = pixel (row r+i, col c+j), i=0 oldest row.
REQ-013 SHALL have port out_col / out_row, output, 12 each, window anchor c / r.
REQ-014 SHALL have port frame_done, output, 1, single-cycle pulse on the cycle after the last pixel of a frame is accepted.

Function
REQ-015 SHALL define accept = in_valid & in_ready, and in_ready = ~out_valid | out_ready (one output register, no combinational in_valid->in_ready path).
REQ-016 SHALL keep column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1), both advancing only on accept; x wraps to 0 and y increments at x=IMG_W-1.
REQ-017 SHALL hold K-1 line delays of IMG_W-K pixels each plus a KxK register window; all shift only on accept.
REQ-018 SHALL implement FSM FILL (y<K-1), RUN (y>=K-1), DONE (one cycle, issues frame_done, clears x/y, returns to FILL); in_ready is 0 in DONE.
REQ-019 SHALL, on accept of pixel (x,y) with x>=K-1 and y>=K-1, register out_win for anchor c=x-K+1, r=y-K+1 and set out_valid the next cycle (latency 1).
REQ-020 SHALL clear out_valid when out_valid & out_ready and no new window is loaded; on simultaneous handoff and load, load the new window with out_valid held at 1.
REQ-021 SHALL hold out_win, out_col and out_row stable while out_valid & ~out_ready.
REQ-022 SHALL emit exactly (IMG_W-K+1)*(IMG_H-K+1) windows per frame; windows with x<K-1 (line wrap) are not emitted.
REQ-023 SHALL not corrupt the window across frames; the first window of frame n+1 contains only frame n+1 pixels.

Reset
REQ-024 SHALL, on rst_n low (any cycle, including mid-frame), force FSM=FILL, x=y=0, out_valid=0, frame_done=0, out_col=out_row=0, in_ready=1 after release; window/line data not reset.

Configuration
REQ-025 SHALL, with macro WINBUF_EOL_FLAGS_EN defined, add outputs out_eol (window c=IMG_W-K) and out_eof (c=IMG_W-K and r=IMG_H-K), both registered with out_win and held under backpressure.
REQ-026 SHALL, without WINBUF_EOL_FLAGS_EN, omit out_eol/out_eof ports and logic; all other behaviour is identical.

Verification (IMG_W=8, IMG_H=6, K=4, pixel = {row,col} hex e.g. 0x23)
REQ-027 Stream one frame, in_valid=out_ready=1 -> first out_valid the cycle after accept of 0x33, out_win slice0=0x00, slice15=0x33; 15 windows total; frame_done once after 48th accept.
REQ-028 Drop out_ready for 5 cycles while out_valid=1 -> in_ready=0, out_win/out_col/out_row unchanged; on release, no window lost or duplicated.
REQ-029 Two frames back to back -> second-frame window sequence identical to first; in_ready=0 for exactly the DONE cycle.
REQ-030 Assert rst_n low after 20 accepts, then resend full frame -> 15 correct windows, no stale pixel in first window.
REQ-031 With WINBUF_EOL_FLAGS_EN -> out_eol=1 on anchors c=4 (r=0..2), out_eof=1 only on (c=4,r=2).
REQ-032 K=2, same image -> 35 windows; first window {0x00,0x01,0x10,0x11}.
